// File: rtl/sram_req_arbiter.sv
// Two-requester sram-like arbiter (inst/data) onto one master port, with an
// in-order outstanding-transaction FIFO that routes responses back to the issuer.
module sram_req_arbiter #(
    parameter int OT_DEPTH   = 4,
    parameter int STARVE_LIM = 4
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       inst_req,
    input  logic                       inst_wr,
    input  logic [1:0]                 inst_size,
    input  logic [31:0]                inst_addr,
    input  logic [3:0]                 inst_wstrb,
    input  logic [31:0]                inst_wdata,
    output logic                       inst_addr_ok,
    output logic                       inst_data_ok,
    output logic [31:0]                inst_rdata,

    input  logic                       data_req,
    input  logic                       data_wr,
    input  logic [1:0]                 data_size,
    input  logic [31:0]                data_addr,
    input  logic [3:0]                 data_wstrb,
    input  logic [31:0]                data_wdata,
    output logic                       data_addr_ok,
    output logic                       data_data_ok,
    output logic [31:0]                data_rdata,

    output logic                       m_req,
    output logic                       m_wr,
    output logic [1:0]                 m_size,
    output logic [31:0]                m_addr,
    output logic [3:0]                 m_wstrb,
    output logic [31:0]                m_wdata,
    input  logic                       m_addr_ok,
    input  logic                       m_data_ok,
    input  logic [31:0]                m_rdata,

    output logic                       resp_err,
    output logic [1:0]                 dbg_state,
    output logic [$clog2(OT_DEPTH):0]  dbg_count
);
    localparam int PW = $clog2(OT_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIM + 1);

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_INST = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_t;

    arb_state_t     state;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [SW-1:0]  streak;
    logic           order_q [OT_DEPTH];   // 0 = inst, 1 = data

    logic grant_data;
    logic req_any;
    logic full;
    logic empty;
    logic starve_hit;
    logic push;
    logic pop;
    logic head;

    assign full       = (count == CW'(OT_DEPTH));
    assign empty      = (count == '0);
    assign starve_hit = (streak == SW'(STARVE_LIM));

    // A locked state keeps the address phase stable until the slave accepts it.
    always_comb begin
        grant_data = 1'b0;
        req_any    = 1'b0;
        case (state)
            ARB_INST: begin
                grant_data = 1'b0;
                req_any    = 1'b1;
            end
            ARB_DATA: begin
                grant_data = 1'b1;
                req_any    = 1'b1;
            end
            default: begin
                grant_data = data_req & (~inst_req | ~starve_hit);
                req_any    = (inst_req | data_req) & ~full;
            end
        endcase
    end

    assign m_req   = req_any & ~reset;
    assign m_wr    = m_req & (grant_data ? data_wr : inst_wr);
    assign m_size  = m_req ? (grant_data ? data_size  : inst_size)  : '0;
    assign m_addr  = m_req ? (grant_data ? data_addr  : inst_addr)  : '0;
    assign m_wstrb = m_req ? (grant_data ? data_wstrb : inst_wstrb) : '0;
    assign m_wdata = m_req ? (grant_data ? data_wdata : inst_wdata) : '0;

    assign push = m_req & m_addr_ok;
    assign pop  = m_data_ok & ~empty & ~reset;
    assign head = order_q[rd_ptr];

    assign inst_addr_ok = push & ~grant_data;
    assign data_addr_ok = push & grant_data;
    assign inst_data_ok = pop & ~head;
    assign data_data_ok = pop & head;
    assign inst_rdata   = m_rdata;
    assign data_rdata   = m_rdata;

    assign dbg_state = state;
    assign dbg_count = count;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ARB_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            streak   <= '0;
            resp_err <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: if (m_req && !m_addr_ok) state <= grant_data ? ARB_DATA : ARB_INST;
                ARB_INST, ARB_DATA: if (m_addr_ok) state <= ARB_IDLE;
                default: state <= ARB_IDLE;
            endcase

            if (push) begin
                order_q[wr_ptr] <= grant_data;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);

            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);

            // Streak counts data wins that actually made inst wait.
            if (push) begin
                if (!grant_data)                           streak <= '0;
                else if (inst_req && !starve_hit)          streak <= streak + SW'(1);
            end

            if (m_data_ok && empty) resp_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: grant priority, lock, starvation,
// FIFO full/routing and orphan-response flag, each checked inline.
module tb_sram_req_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic [3:0]  inst_wstrb, data_wstrb;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    logic        m_addr_ok, m_data_ok;
    logic        resp_err;
    logic [1:0]  dbg_state;
    logic [2:0]  dbg_count;

    int n_vec = 0;
    int n_err = 0;

    sram_req_arbiter #(.OT_DEPTH(4), .STARVE_LIM(4)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wstrb(m_wstrb),
        .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .resp_err(resp_err), .dbg_state(dbg_state), .dbg_count(dbg_count)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; checks run 1ns later, clear of posedge.
    task automatic clear_inputs();
        inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wstrb = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wstrb = 0; data_wdata = 0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        reset = 1;
        @(negedge clk);
        reset = 0;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1; inst_req = 1; data_req = 1; m_addr_ok = 1; m_data_ok = 1;
        #1;
        n_vec++; if (m_req !== 1'b0) begin n_err++; $display("FAIL rst_m_req got %b exp 0", m_req); end
        n_vec++; if ({inst_addr_ok, data_addr_ok} !== 2'b00) begin n_err++; $display("FAIL rst_addr_ok got %b exp 00", {inst_addr_ok, data_addr_ok}); end
        n_vec++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin n_err++; $display("FAIL rst_data_ok got %b exp 00", {inst_data_ok, data_data_ok}); end
        @(negedge clk);
        clear_inputs();
        reset = 0;
        inst_addr = 32'hDEAD_BEEF; inst_wdata = 32'h1234_5678;
        #1;
        n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL rst_state got %0d exp 0", dbg_state); end
        n_vec++; if (dbg_count !== 3'd0) begin n_err++; $display("FAIL rst_count got %0d exp 0", dbg_count); end
        n_vec++; if (resp_err !== 1'b0) begin n_err++; $display("FAIL rst_resp_err got %b exp 0", resp_err); end
        n_vec++; if ({m_addr, m_wdata} !== 64'h0) begin n_err++; $display("FAIL idle_payload got %h exp 0", {m_addr, m_wdata}); end
    endtask

    task automatic test_single_read();
        do_reset();
        @(negedge clk);
        inst_req = 1; inst_addr = 32'h1C00_0000; inst_size = 2'd2; m_addr_ok = 1;
        #1;
        n_vec++; if (m_addr !== 32'h1C00_0000) begin n_err++; $display("FAIL sr_m_addr got %h exp 1c000000", m_addr); end
        n_vec++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin n_err++; $display("FAIL sr_addr_ok got %b exp 10", {inst_addr_ok, data_addr_ok}); end
        n_vec++; if (m_size !== 2'd2) begin n_err++; $display("FAIL sr_m_size got %0d exp 2", m_size); end
        @(negedge clk);
        inst_req = 0; m_addr_ok = 0;
        #1;
        n_vec++; if (dbg_count !== 3'd1) begin n_err++; $display("FAIL sr_count got %0d exp 1", dbg_count); end
        @(negedge clk);
        m_data_ok = 1; m_rdata = 32'h0280_0000;
        #1;
        n_vec++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin n_err++; $display("FAIL sr_data_ok got %b exp 10", {inst_data_ok, data_data_ok}); end
        n_vec++; if (inst_rdata !== 32'h0280_0000) begin n_err++; $display("FAIL sr_inst_rdata got %h exp 02800000", inst_rdata); end
        n_vec++; if (data_rdata !== 32'h0280_0000) begin n_err++; $display("FAIL sr_data_rdata got %h exp 02800000", data_rdata); end
        @(negedge clk);
        m_data_ok = 0;
        #1;
        n_vec++; if (dbg_count !== 3'd0) begin n_err++; $display("FAIL sr_count_end got %0d exp 0", dbg_count); end
        n_vec++; if (resp_err !== 1'b0) begin n_err++; $display("FAIL sr_resp_err got %b exp 0", resp_err); end
    endtask

    task automatic test_priority();
        do_reset();
        @(negedge clk);
        inst_req = 1; inst_addr = 32'h1C00_0000;
        data_req = 1; data_addr = 32'h0000_1000; data_wr = 1; data_wstrb = 4'hF; data_wdata = 32'hCAFE_F00D;
        m_addr_ok = 1;
        #1;
        n_vec++; if (m_addr !== 32'h0000_1000) begin n_err++; $display("FAIL pr_m_addr got %h exp 00001000", m_addr); end
        n_vec++; if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin n_err++; $display("FAIL pr_addr_ok got %b exp 01", {inst_addr_ok, data_addr_ok}); end
        n_vec++; if ({m_wr, m_wstrb, m_wdata} !== {1'b1, 4'hF, 32'hCAFE_F00D}) begin n_err++; $display("FAIL pr_payload got %h exp 1fcafef00d", {m_wr, m_wstrb, m_wdata}); end
        @(negedge clk);
        clear_inputs();
        m_data_ok = 1;
        #1;
        n_vec++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin n_err++; $display("FAIL pr_data_ok got %b exp 01", {inst_data_ok, data_data_ok}); end
    endtask

    task automatic test_lock();
        do_reset();
        @(negedge clk);
        inst_req = 1; inst_addr = 32'h1C00_0040;
        #1;
        n_vec++; if (m_addr !== 32'h1C00_0040) begin n_err++; $display("FAIL lk_c0_addr got %h exp 1c000040", m_addr); end
        n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL lk_c0_state got %0d exp 0", dbg_state); end
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            data_req = 1; data_addr = 32'h0000_2000;
            m_addr_ok = (c == 3);
            #1;
            n_vec++; if (m_addr !== 32'h1C00_0040) begin n_err++; $display("FAIL lk_c%0d_addr got %h exp 1c000040", c, m_addr); end
            n_vec++; if (dbg_state !== 2'd1) begin n_err++; $display("FAIL lk_c%0d_state got %0d exp 1", c, dbg_state); end
            n_vec++; if ({inst_addr_ok, data_addr_ok} !== {(c == 3), 1'b0}) begin n_err++; $display("FAIL lk_c%0d_addr_ok got %b exp %b", c, {inst_addr_ok, data_addr_ok}, {(c == 3), 1'b0}); end
        end
        @(negedge clk);
        inst_req = 0; m_addr_ok = 0;
        #1;
        n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL lk_c4_state got %0d exp 0", dbg_state); end
        n_vec++; if (m_addr !== 32'h0000_2000) begin n_err++; $display("FAIL lk_c4_addr got %h exp 00002000", m_addr); end
    endtask

    task automatic test_starve();
        logic exp_d [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            inst_req = 1; inst_addr = 32'h1C00_0000 + i;
            data_req = 1; data_addr = 32'h0000_3000 + i;
            m_addr_ok = 1; m_data_ok = (i != 0);
            #1;
            n_vec++; if ({inst_addr_ok, data_addr_ok} !== {~exp_d[i], exp_d[i]}) begin n_err++; $display("FAIL st_grant%0d got %b exp %b", i, {inst_addr_ok, data_addr_ok}, {~exp_d[i], exp_d[i]}); end
            if (i != 0) begin
                n_vec++; if ({inst_data_ok, data_data_ok} !== {~exp_d[i-1], exp_d[i-1]}) begin n_err++; $display("FAIL st_route%0d got %b exp %b", i, {inst_data_ok, data_data_ok}, {~exp_d[i-1], exp_d[i-1]}); end
                n_vec++; if (dbg_count !== 3'd1) begin n_err++; $display("FAIL st_count%0d got %0d exp 1", i, dbg_count); end
            end
        end
    endtask

    task automatic test_full();
        logic exp_pop [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            inst_req = (i % 2 == 0); data_req = (i % 2 == 1); m_addr_ok = 1;
            #1;
            n_vec++; if ({inst_addr_ok, data_addr_ok} !== {(i % 2 == 0), (i % 2 == 1)}) begin n_err++; $display("FAIL fu_push%0d got %b", i, {inst_addr_ok, data_addr_ok}); end
        end
        @(negedge clk);
        inst_req = 1; data_req = 0;
        #1;
        n_vec++; if (m_req !== 1'b0) begin n_err++; $display("FAIL fu_full_m_req got %b exp 0", m_req); end
        n_vec++; if (dbg_count !== 3'd4) begin n_err++; $display("FAIL fu_count got %0d exp 4", dbg_count); end
        @(negedge clk);
        m_data_ok = 1;
        #1;
        n_vec++; if (m_req !== 1'b0) begin n_err++; $display("FAIL fu_pop_m_req got %b exp 0", m_req); end
        n_vec++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin n_err++; $display("FAIL fu_pop0 got %b exp 10", {inst_data_ok, data_data_ok}); end
        @(negedge clk);
        m_data_ok = 0;
        #1;
        n_vec++; if ({m_req, inst_addr_ok} !== 2'b11) begin n_err++; $display("FAIL fu_refill got %b exp 11", {m_req, inst_addr_ok}); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            inst_req = 0; m_addr_ok = 0; m_data_ok = 1;
            #1;
            n_vec++; if ({inst_data_ok, data_data_ok} !== {~exp_pop[i], exp_pop[i]}) begin n_err++; $display("FAIL fu_drain%0d got %b exp %b", i, {inst_data_ok, data_data_ok}, {~exp_pop[i], exp_pop[i]}); end
        end
        @(negedge clk);
        m_data_ok = 0;
        #1;
        n_vec++; if (dbg_count !== 3'd0) begin n_err++; $display("FAIL fu_empty got %0d exp 0", dbg_count); end
    endtask

    task automatic test_resp_err();
        do_reset();
        @(negedge clk);
        m_data_ok = 1;
        #1;
        n_vec++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin n_err++; $display("FAIL re_orphan_ok got %b exp 00", {inst_data_ok, data_data_ok}); end
        @(negedge clk);
        m_data_ok = 0; inst_req = 1; m_addr_ok = 1;
        #1;
        n_vec++; if (resp_err !== 1'b1) begin n_err++; $display("FAIL re_set got %b exp 1", resp_err); end
        n_vec++; if (dbg_count !== 3'd0) begin n_err++; $display("FAIL re_count got %0d exp 0", dbg_count); end
        @(negedge clk);
        inst_req = 0; m_addr_ok = 0; m_data_ok = 1;
        #1;
        n_vec++; if (inst_data_ok !== 1'b1) begin n_err++; $display("FAIL re_traffic_ok got %b exp 1", inst_data_ok); end
        step();
        n_vec++; if (resp_err !== 1'b1) begin n_err++; $display("FAIL re_sticky got %b exp 1", resp_err); end
        do_reset();
        #1;
        n_vec++; if (resp_err !== 1'b0) begin n_err++; $display("FAIL re_clear got %b exp 0", resp_err); end
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        repeat (2) @(negedge clk);
        test_reset();
        test_single_read();
        test_priority();
        test_lock();
        test_starve();
        test_full();
        test_resp_err();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sram_req_arbiter.md
SRAM_REQ_ARBITER -- requirements
Module: sram_req_arbiter

Interface
REQ-001 SHALL have parameter OT_DEPTH, default 4: outstanding-transaction FIFO depth, power of two.
REQ-002 SHALL have parameter STARVE_LIM, default 4: consecutive contested data grants before inst is forced.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports inst_req / inst_wr, input, 1 each: inst requester request and write flag.
REQ-006 SHALL have ports inst_size, input, 2; inst_addr, input, 32; inst_wstrb, input, 4; inst_wdata, input, 32: inst request payload.
REQ-007 SHALL have ports inst_addr_ok / inst_data_ok, output, 1 each; inst_rdata, output, 32: inst responses.
REQ-008 SHALL have ports data_req / data_wr / data_size / data_addr / data_wstrb / data_wdata, input, 1/1/2/32/4/32: data requester, same meaning as the inst ports.
REQ-009 SHALL have ports data_addr_ok / data_data_ok, output, 1 each; data_rdata, output, 32: data responses.
REQ-010 SHALL have ports m_req / m_wr / m_size / m_addr / m_wstrb / m_wdata, output, 1/1/2/32/4/32: shared sram-like master toward the AXI bridge.
REQ-011 SHALL have ports m_addr_ok / m_data_ok, input, 1 each; m_rdata, input, 32: master responses.
REQ-012 SHALL have port resp_err, output, 1: sticky flag, m_data_ok seen with no outstanding transaction.

Function
REQ-013 SHALL implement FSM states ARB_IDLE, ARB_INST, ARB_DATA.
REQ-014 ARB_IDLE: grant chosen combinationally same cycle; m_req = (inst_req | data_req) & ~full.
REQ-015 Grant choice: data wins when both request, except inst wins when streak == STARVE_LIM; sole requester always wins.
REQ-016 m_wr/m_size/m_addr/m_wstrb/m_wdata SHALL mux from the granted source; all zero when m_req = 0.
REQ-017 ARB_IDLE with m_req=1 and m_addr_ok=0 -> ARB_INST or ARB_DATA per grant; otherwise stay ARB_IDLE.
REQ-018 ARB_INST/ARB_DATA: grant locked to that source, m_req=1, other source ignored; -> ARB_IDLE on m_addr_ok.
REQ-019 inst_addr_ok = m_req & m_addr_ok & grant==inst; data_addr_ok likewise; never both.
REQ-020 On m_req & m_addr_ok, push granted source id (0 inst, 1 data) into order FIFO.
REQ-021 full = (count == OT_DEPTH); full SHALL suppress new grants in ARB_IDLE regardless of same-cycle pop.
REQ-022 On m_data_ok with count>0: pop head; assert data_ok only on head's port, same cycle (zero latency).
REQ-023 Simultaneous push and pop: both pointers advance, count unchanged.
REQ-024 Pointers wrap modulo OT_DEPTH; count width log2(OT_DEPTH)+1.
REQ-025 m_data_ok with count==0: no port data_ok, no pointer change, resp_err set and held until reset.
REQ-026 inst_rdata and data_rdata SHALL both equal m_rdata combinationally.
REQ-027 streak: +1 (saturating at STARVE_LIM) on accepted data grant while inst_req=1; cleared on accepted inst grant; else held.

Reset
REQ-028 On reset: state ARB_IDLE, FIFO pointers/count 0, streak 0, resp_err 0.
REQ-029 During reset all *_addr_ok, *_data_ok and m_req SHALL be 0; in-flight transactions discarded.

Verification
REQ-030 inst_req, inst_addr=0x1C000000, m_addr_ok same cycle -> inst_addr_ok=1, count=1; later m_data_ok, m_rdata=0x02800000 -> inst_data_ok=1, inst_rdata=0x02800000, data_data_ok=0.
REQ-031 inst_req and data_req same cycle, streak=0, data_addr=0x00001000 -> m_addr=0x00001000, data_addr_ok=1, inst_addr_ok=0.
REQ-032 inst granted, m_addr_ok delayed 3 cycles, data_req rises cycle 1 -> m_addr stays inst_addr for all 4 cycles, state ARB_INST cycles 1-3.
REQ-033 Both requesting continuously, m_addr_ok and m_data_ok every cycle -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-034 Four accepted, no m_data_ok -> fifth cycle m_req=0; one m_data_ok -> m_req=1 next cycle; data_ok routing matches push order.
REQ-035 m_data_ok with empty FIFO -> resp_err=1, stays 1 through further traffic, cleared only by reset.
